dmem_arbiter: RTL

Two-port arbiter that shares the single-port synchronous data RAM between the multicycle CPU core (port 0) and the program loader/debug port (port 1).
- Each port uses a req/ack handshake and submits one word transaction at a time.
- The arbiter serialises transactions, drives the RAM, and returns read data with a one-cycle ack pulse.
- It sits between the CPU data-memory interface and the data RAM instance.

---
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port req/ack arbiter in front of the single-port synchronous data RAM.
// Serialises one word transaction at a time; read data is returned with a one-cycle ack.
module dmem_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int FIXED_PRI = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [3:0]        p0_be,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [3:0]        p1_be,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_lat_check
        $error("dmem_arbiter: RD_LAT must be in 1..4");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, ACK} state_t;

    localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic [1:0]        lat_q, lat_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lat_q    <= 2'd0;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= 4'h0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        sel      = 1'b0;

        // On a tie, round-robin favours the port that did not win last time.
        if (p0_req && p1_req) sel = (FIXED_PRI != 0) ? 1'b0 : ~last_q;
        else                  sel = p1_req;

        case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    gnt_d   = sel;
                    last_d  = sel;
                    we_d    = sel ? p1_we    : p0_we;
                    addr_d  = sel ? p1_addr  : p0_addr;
                    wdata_d = sel ? p1_wdata : p0_wdata;
                    be_d    = sel ? p1_be    : p0_be;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = ACK;
                end else begin
                    lat_d   = LAT_INIT;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (lat_q != 2'd0) begin
                    lat_d = lat_q - 2'd1;
                end else begin
                    if (gnt_q) rdata1_d = mem_rdata;
                    else       rdata0_d = mem_rdata;
                    state_d = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_en    = (state_q == ISSUE);
    assign mem_we    = (state_q == ISSUE) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign p0_ack    = (state_q == ACK) && !gnt_q;
    assign p1_ack    = (state_q == ACK) && gnt_q;
    assign p0_rdata  = rdata0_q;
    assign p1_rdata  = rdata1_q;
    assign busy      = (state_q != IDLE);

endmodule
